// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//
// Shares the single data-memory port between the CPU load/store path and the
// serial debug reader. One request is latched at a time. The arbiter issues it
// to memory, waits out the fixed read latency, and routes read data back to
// whichever requester issued the read. This block is the only driver of the
// memory read/write strobes.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cpu_req/we/addr/wdata           CPU request; held stable until cpu_gnt
//   cpu_gnt, cpu_rvalid             one-cycle pulses: access issued / rdata valid
//   cpu_rdata                       CPU read data, held until next CPU response
//   dbg_req/we/addr/wdata           debug request, same protocol as the CPU
//   dbg_gnt, dbg_rvalid, dbg_rdata  debug equivalents of the CPU outputs
//   mem_addr, mem_wdata             memory address / write data
//   mem_wr, mem_rd                  memory write / read strobes (never both high)
//   mem_rdata                       memory read data, valid RD_LAT cycles after mem_rd
//   busy                            high whenever the FSM is not in IDLE

module data_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(MAX_WAIT);
    localparam logic [1:0] WAIT_INIT    = 2'(RD_LAT - 1);

    state_t     state;
    logic [3:0] starve_cnt;
    logic [1:0] wait_cnt;
    // 0 = CPU owns the access in flight, 1 = debug owns it
    logic       owner_dbg;
    logic       dbg_wins;

    // Debug wins when it is alone, or when it has been passed over often enough
    assign dbg_wins = dbg_req && (!cpu_req || (starve_cnt == STARVE_LIMIT));

    assign busy = (state != IDLE);

    // Strobes and pulses default low every cycle. The request fields are
    // latched straight into mem_addr/mem_wdata, so the address stays on the
    // memory port for the whole access, including the WAIT cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            owner_dbg  <= 1'b0;
            cpu_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dbg_gnt    <= 1'b0;
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wr     <= 1'b0;
            mem_rd     <= 1'b0;
        end else begin
            cpu_gnt    <= 1'b0;
            dbg_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            mem_wr     <= 1'b0;
            mem_rd     <= 1'b0;

            case (state)
                IDLE: begin
                    if (cpu_req || dbg_req) begin
                        state <= ISSUE;
                        if (dbg_wins) begin
                            owner_dbg  <= 1'b1;
                            dbg_gnt    <= 1'b1;
                            mem_addr   <= dbg_addr;
                            mem_wdata  <= dbg_wdata;
                            mem_wr     <= dbg_we;
                            mem_rd     <= ~dbg_we;
                            starve_cnt <= '0;
                        end else begin
                            owner_dbg  <= 1'b0;
                            cpu_gnt    <= 1'b1;
                            mem_addr   <= cpu_addr;
                            mem_wdata  <= cpu_wdata;
                            mem_wr     <= cpu_we;
                            mem_rd     <= ~cpu_we;
                            if (dbg_req && (starve_cnt != STARVE_LIMIT)) begin
                                starve_cnt <= starve_cnt + 4'd1;
                            end
                        end
                    end
                end

                // mem_wr still reflects the latched direction during ISSUE
                ISSUE: begin
                    if (mem_wr) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= WAIT_INIT;
                        state    <= WAIT;
                    end
                end

                // The last WAIT cycle is the one where mem_rdata is valid
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state <= RESP;
                        if (owner_dbg) begin
                            dbg_rdata  <= mem_rdata;
                            dbg_rvalid <= 1'b1;
                        end else begin
                            cpu_rdata  <= mem_rdata;
                            cpu_rvalid <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
//
// Directed bench for data_mem_arbiter with RD_LAT=2 and MAX_WAIT=3.
// A small memory model answers reads RD_LAT cycles after mem_rd and
// stores writes. Every expected value is a hand-computed constant.

module tb_data_mem_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt, cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              dbg_req, dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt, dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wr, mem_rd;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RD_LAT  (RD_LAT),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata (cpu_rdata),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_gnt   (dbg_gnt),
        .dbg_rvalid(dbg_rvalid),
        .dbg_rdata (dbg_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr    (mem_wr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Memory model: 256 words addressed by mem_addr[7:0]. A read launched in
    // cycle n returns data during cycle n+2 and garbage otherwise.
    logic [DATA_W-1:0] mem_array [0:255];
    logic              rd_v1, rd_v2;
    logic [7:0]        rd_a1, rd_a2;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem_array[i] <= '0;
        end else if (mem_wr) begin
            mem_array[mem_addr[7:0]] <= mem_wdata;
        end
        rd_v1 <= mem_rd;
        rd_a1 <= mem_addr[7:0];
        rd_v2 <= rd_v1;
        rd_a2 <= rd_a1;
    end

    assign mem_rdata = rd_v2 ? mem_array[rd_a2] : 32'hBAAD_F00D;

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic c_req, input logic c_we,
                                  input logic [31:0] c_addr, input logic [31:0] c_wdata,
                                  input logic d_req, input logic d_we,
                                  input logic [31:0] d_addr, input logic [31:0] d_wdata);
        cpu_req   = c_req;
        cpu_we    = c_we;
        cpu_addr  = c_addr;
        cpu_wdata = c_wdata;
        dbg_req   = d_req;
        dbg_we    = d_we;
        dbg_addr  = d_addr;
        dbg_wdata = d_wdata;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " flags"},
                     {57'd0, cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_wr, mem_rd, busy}, 64'd0);
        check_output({tag, " cpu_rdata"}, cpu_rdata, 64'd0);
        check_output({tag, " dbg_rdata"}, dbg_rdata, 64'd0);
        check_output({tag, " mem_addr"},  mem_addr,  64'd0);
        check_output({tag, " mem_wdata"}, mem_wdata, 64'd0);
    endtask

    logic exp_dbg_order [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        // 1: reset for two cycles with garbage on every input
        reset = 1'b1;
        apply_stimulus(1'b1, 1'b1, 32'hFFFF_FFF0, 32'hA5A5_A5A5,
                       1'b1, 1'b0, 32'h1234_5670, 32'h5A5A_5A5A);
        tick();
        check_all_zero("reset cycle 1");
        tick();
        check_all_zero("reset cycle 2");
        reset = 1'b0;
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        tick();
        check_all_zero("after reset");

        // 2: CPU write 0xDEADBEEF to 0x10
        $display("[TB] CPU write");
        apply_stimulus(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, '0);
        tick();
        check_output("wr cpu_gnt",   cpu_gnt,   64'd1);
        check_output("wr dbg_gnt",   dbg_gnt,   64'd0);
        check_output("wr mem_wr",    mem_wr,    64'd1);
        check_output("wr mem_rd",    mem_rd,    64'd0);
        check_output("wr mem_addr",  mem_addr,  64'h10);
        check_output("wr mem_wdata", mem_wdata, 64'hDEAD_BEEF);
        cpu_req = 1'b0;
        tick();
        check_output("wr busy after", busy, 64'd0);
        check_output("wr gnt after",  cpu_gnt, 64'd0);

        // 3: CPU read of 0x10
        $display("[TB] CPU read");
        apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, '0, '0);
        tick();
        check_output("rd cpu_gnt",  cpu_gnt,  64'd1);
        check_output("rd mem_rd",   mem_rd,   64'd1);
        check_output("rd mem_wr",   mem_wr,   64'd0);
        check_output("rd mem_addr", mem_addr, 64'h10);
        cpu_req = 1'b0;
        tick();
        check_output("rd c2 mem_rd",  mem_rd,  64'd0);
        check_output("rd c2 addr",    mem_addr, 64'h10);
        check_output("rd c2 busy",    busy,    64'd1);
        tick();
        check_output("rd c3 rvalid",  cpu_rvalid, 64'd0);
        tick();
        check_output("rd c4 cpu_rvalid", cpu_rvalid, 64'd1);
        check_output("rd c4 cpu_rdata",  cpu_rdata,  64'hDEAD_BEEF);
        check_output("rd c4 dbg_rvalid", dbg_rvalid, 64'd0);
        check_output("rd c4 busy",       busy,       64'd1);
        tick();
        check_output("rd c5 cpu_rvalid", cpu_rvalid, 64'd0);
        check_output("rd c5 busy",       busy,       64'd0);
        for (int c = 6; c <= 10; c++) tick();
        check_output("rd c10 cpu_rdata", cpu_rdata, 64'hDEAD_BEEF);

        // 4: both requesters write continuously; debug wins every fourth grant
        $display("[TB] contention");
        apply_stimulus(1'b1, 1'b1, 32'h20, 32'hCAFE_0020,
                       1'b1, 1'b1, 32'h40, 32'h1234_5678);
        for (int g = 0; g < 8; g++) begin
            tick();
            check_output($sformatf("arb %0d cpu_gnt", g), cpu_gnt, {63'd0, ~exp_dbg_order[g]});
            check_output($sformatf("arb %0d dbg_gnt", g), dbg_gnt, {63'd0, exp_dbg_order[g]});
            check_output($sformatf("arb %0d mem_addr", g), mem_addr,
                         exp_dbg_order[g] ? 64'h40 : 64'h20);
            check_output($sformatf("arb %0d mem_wr", g), mem_wr, 64'd1);
            if (g == 7) begin
                cpu_req = 1'b0;
                dbg_req = 1'b0;
            end
            tick();
            check_output($sformatf("arb %0d idle gnts", g), {62'd0, cpu_gnt, dbg_gnt}, 64'd0);
            check_output($sformatf("arb %0d idle busy", g), busy, 64'd0);
        end

        // 5: debug read of 0x40 while the CPU is quiet
        $display("[TB] debug read");
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h40, 32'h0);
        tick();
        check_output("dbg c1 dbg_gnt",  dbg_gnt,  64'd1);
        check_output("dbg c1 cpu_gnt",  cpu_gnt,  64'd0);
        check_output("dbg c1 mem_rd",   mem_rd,   64'd1);
        check_output("dbg c1 mem_addr", mem_addr, 64'h40);
        dbg_req = 1'b0;
        tick();
        tick();
        check_output("dbg c3 dbg_rvalid", dbg_rvalid, 64'd0);
        tick();
        check_output("dbg c4 dbg_rvalid", dbg_rvalid, 64'd1);
        check_output("dbg c4 dbg_rdata",  dbg_rdata,  64'h1234_5678);
        check_output("dbg c4 cpu_rvalid", cpu_rvalid, 64'd0);
        check_output("dbg c4 cpu_rdata",  cpu_rdata,  64'hDEAD_BEEF);
        tick();

        // 6: CPU read abandoned by reset during WAIT
        $display("[TB] reset mid-read");
        apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, '0, '0);
        tick();
        check_output("abort c1 cpu_gnt", cpu_gnt, 64'd1);
        cpu_req = 1'b0;
        tick();
        check_output("abort c2 busy", busy, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("abort c3");
        for (int c = 4; c <= 8; c++) begin
            tick();
            check_output($sformatf("abort c%0d cpu_rvalid", c), cpu_rvalid, 64'd0);
            check_output($sformatf("abort c%0d busy", c), busy, 64'd0);
        end
        apply_stimulus(1'b1, 1'b1, 32'h30, 32'h0BAD_CAFE, 1'b0, 1'b0, '0, '0);
        tick();
        check_output("post cpu_gnt",   cpu_gnt,   64'd1);
        check_output("post mem_wr",    mem_wr,    64'd1);
        check_output("post mem_addr",  mem_addr,  64'h30);
        check_output("post mem_wdata", mem_wdata, 64'h0BAD_CAFE);
        cpu_req = 1'b0;
        tick();
        check_output("post busy", busy, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the CPU load/store path and the serial debug reader.
- Arbitrates between them, latches the winning request and issues exactly one memory access at a time.
- Sequences the fixed read latency and routes read data back to the requester that issued the read.
- Sits between the CPU datapath/debug interface and the memory block. It is the only driver of the memory read/write strobes.

Parameters:
- ADDR_W, 32, width of address fields.
- DATA_W, 32, width of data fields.
- RD_LAT, 1, cycles from mem_rd high to mem_rdata valid; legal range 1..4.
- MAX_WAIT, 4, number of lost arbitrations the debug requester tolerates before it is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held with stable fields until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  one-cycle pulse: CPU access issued
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
- cpu_rdata  out  DATA_W  CPU read data; held until next CPU response
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug equivalents of the CPU inputs
- dbg_gnt, dbg_rvalid  out  1  debug equivalents of the CPU outputs
- dbg_rdata  out  DATA_W  debug read data; held until next debug response
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wr  out  1  memory write strobe
- mem_rd  out  1  memory read strobe
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (synchronous, active-high; clock clk): state = IDLE, starvation counter = 0. Every output is 0, including rdata and mem_* outputs.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples the requests each cycle.
  - If any request is present: selects a winner, registers its we/addr/wdata and owner ID, and goes to ISSUE.
  - If no request is present: stays in IDLE.
- Arbitration:
  - A lone request wins.
  - If both requests are present, the CPU wins unless the starvation counter = MAX_WAIT, in which case debug wins.
  - The counter increments, saturating at MAX_WAIT, on each IDLE arbitration where dbg_req = 1 and the CPU wins.
  - The counter clears when debug is granted.
- ISSUE (one cycle):
  - mem_addr and mem_wdata are driven from the registered request.
  - mem_wr = we, mem_rd = ~we.
  - The owner's gnt pulses high. The requester may change its fields from the next cycle.
  - For a write, go to IDLE. For a read, go to WAIT with wait count = RD_LAT − 1.
- WAIT:
  - mem_rd = 0 and mem_addr is held.
  - Count down to 0. mem_rdata is captured in the cycle RD_LAT cycles after ISSUE.
  - When RD_LAT = 1, capture happens in the first WAIT cycle.
  - Then go to RESP.
- RESP (one cycle):
  - The owner's rvalid = 1 and the owner's rdata register is updated.
  - No arbitration takes place. Go to IDLE.
- Timing with the request sampled in cycle 0:
  - Write: gnt and mem_wr in cycle 1; next arbitration in cycle 2.
  - Read: gnt and mem_rd in cycle 1, rvalid in cycle 2+RD_LAT, next arbitration in cycle 3+RD_LAT.
- Mutual exclusion:
  - Never more than one gnt or rvalid high in the same cycle.
  - mem_rd and mem_wr are never both high.
  - rvalid only goes to the owner of the read.
- A request that drops before its grant is ignored only if it drops before IDLE samples it. Once latched, the access completes.
- Reset asserted mid-access (ISSUE, WAIT or RESP): the access is abandoned and no rvalid is produced. IDLE with all outputs 0 follows the reset cycle.
- Address and data widths pass through unmodified; no alignment checking.

Test Plan:
All scenarios use RD_LAT=2 and MAX_WAIT=3.
1. Reset held for 2 cycles, with garbage on all inputs → all outputs 0 and busy=0 throughout reset and in the first cycle after.
2. cpu_req=1, cpu_we=1, addr 0x10, wdata 0xDEADBEEF sampled in cycle 0 → cycle 1: mem_wr=1, mem_addr=0x10, mem_wdata=0xDEADBEEF, cpu_gnt=1. Cycle 2: busy=0.
3. CPU read of 0x10, memory model returns 0xDEADBEEF in cycle 3 → cpu_rvalid=1 and cpu_rdata=0xDEADBEEF in cycle 4; dbg_rvalid stays 0. cpu_rdata still 0xDEADBEEF in cycle 10.
4. Both requesters issue continuous writes (addr 0x20 CPU, 0x40 debug) → grant order CPU, CPU, CPU, DBG, CPU, CPU, CPU, DBG. No cycle has two gnts.
5. dbg read of 0x40 (memory data 0x12345678) while cpu_req=0 → dbg_gnt in cycle 1, dbg_rvalid with dbg_rdata=0x12345678 in cycle 4, cpu_rvalid=0.
6. CPU read issued, then reset asserted in the WAIT cycle → no cpu_rvalid ever appears. busy=0 the cycle after reset. A new CPU write afterwards gets cpu_gnt one cycle after being sampled.
